// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of the 16-bit CPU core. Holds the program counter,
// drives the fetch and prefetch line addresses to the two-bank instruction
// cache, and assembles the opcode word (ir_out) and the 16-bit immediate word
// (k16_out) from the data the cache returns one cycle later.
//
// Configuration macro:
//   FETCH_UNALIGNED_EN  defined   -> an instruction may start on the odd word
//                                    of a line; its immediate then comes from
//                                    bank A of the next line (prefetch_opc).
//                       undefined -> every capture is treated as line-aligned;
//                                    prefetch_opc is unused. prefetch_out is
//                                    still driven.
//
// Parameters:
//   RESET_PC      PC value loaded on reset (bit 0 is forced to 0).
//
// Ports:
//   clk           rising-edge clock
//   a_rst         asynchronous active-low reset
//   fetch_opc     bank A (even) word of the line at pc_out, 1-cycle latency
//   fetch_arg     bank B (odd) word of the line at pc_out, 1-cycle latency
//   prefetch_opc  bank A word of the line at prefetch_out, 1-cycle latency
//   hold          stall: freeze all state
//   pc_w          load PC from pc_alu (branch/jump), drops ir_valid
//   pc_alu        branch target byte address (bit 0 ignored)
//   pc_inc        PC += 2
//   pc_i2         PC += 4 (wins over pc_inc)
//   pc_inv        next IR capture is marked not valid
//   pc_out        current PC, byte address
//   prefetch_out  next line address {pc_out[15:2]+1, 2'b00}
//   ir_out        captured opcode word
//   k16_out       captured immediate word
//   ir_valid      ir_out/k16_out hold a valid instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic [15:0] fetch_opc,
  input  logic [15:0] fetch_arg,
  input  logic [15:0] prefetch_opc,
  input  logic        hold,
  input  logic        pc_w,
  input  logic [15:0] pc_alu,
  input  logic        pc_inc,
  input  logic        pc_i2,
  input  logic        pc_inv,
  output logic [15:0] pc_out,
  output logic [15:0] prefetch_out,
  output logic [15:0] ir_out,
  output logic [15:0] k16_out,
  output logic        ir_valid
);

  localparam logic [15:0] RESET_PC_EVEN = {RESET_PC[15:1], 1'b0};

  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic        req_q;
  logic        align_q;
  logic [15:0] ir_d;
  logic [15:0] k16_d;
  logic        ir_valid_d;

  // ---------------------------------------------------------------------------
  // Next-PC selection. hold has top priority, then redirect, then the two
  // sequential increments. Arithmetic wraps naturally at 16 bits.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pc_d = pc_q;
    if (!hold) begin
      if (pc_w) begin
        pc_d = {pc_alu[15:1], 1'b0};
      end else if (pc_i2) begin
        pc_d = pc_q + 16'd4;
      end else if (pc_inc) begin
        pc_d = pc_q + 16'd2;
      end
    end
  end

  assign pc_out       = pc_q;
  assign prefetch_out = {pc_q[15:2] + 14'd1, 2'b00};

  // ---------------------------------------------------------------------------
  // Capture mux. align_q remembers which half of the line the PC pointed at
  // when the address went out, so it lines up with the returning data.
  // An odd-word start takes its opcode from bank B and its immediate from
  // bank A of the following line.
  // ---------------------------------------------------------------------------
  always_comb begin
    ir_d  = fetch_opc;
    k16_d = fetch_arg;
`ifdef FETCH_UNALIGNED_EN
    if (align_q) begin
      ir_d  = fetch_arg;
      k16_d = prefetch_opc;
    end
`endif
  end

  // A redirect or invalidate kills the capture at this edge and, through
  // req_q, the one after it: the data for the new PC arrives one edge later.
  assign ir_valid_d = req_q & ~pc_w & ~pc_inv;

  // ---------------------------------------------------------------------------
  // State registers. All state freezes while hold is high.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      pc_q     <= RESET_PC_EVEN;
      req_q    <= 1'b0;
      ir_out   <= 16'h0000;
      k16_out  <= 16'h0000;
      ir_valid <= 1'b0;
    end else if (!hold) begin
      pc_q     <= pc_d;
      req_q    <= ~pc_w & ~pc_inv;
      ir_out   <= ir_d;
      k16_out  <= k16_d;
      ir_valid <= ir_valid_d;
    end
  end

`ifdef FETCH_UNALIGNED_EN
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      align_q <= 1'b0;
    end else if (!hold) begin
      align_q <= pc_q[1];
    end
  end

  logic unused_pc_alu_lsb;
  assign unused_pc_alu_lsb = pc_alu[0];
`else
  // Without unaligned support every capture uses the aligned path.
  assign align_q = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{prefetch_opc, pc_alu[0], align_q};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural cache returns, one cycle after
// the address, the word at byte address a holding value a/2. The driver
// pushes each hand-computed valid capture {ir_out, k16_out} into a queue; an
// independent monitor pops and compares every time the DUT presents a valid
// instruction after a non-hold edge. Direct checks cover PC, prefetch address,
// reset values, hold behaviour and ir_valid drops.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        a_rst = 1'b0;
  logic [15:0] fetch_opc = '0;
  logic [15:0] fetch_arg = '0;
  logic [15:0] prefetch_opc = '0;
  logic        hold = 1'b0;
  logic        pc_w = 1'b0;
  logic [15:0] pc_alu = '0;
  logic        pc_inc = 1'b0;
  logic        pc_i2 = 1'b0;
  logic        pc_inv = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] prefetch_out;
  logic [15:0] ir_out;
  logic [15:0] k16_out;
  logic        ir_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic        last_hold = 1'b0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .fetch_opc    (fetch_opc),
    .fetch_arg    (fetch_arg),
    .prefetch_opc (prefetch_opc),
    .hold         (hold),
    .pc_w         (pc_w),
    .pc_alu       (pc_alu),
    .pc_inc       (pc_inc),
    .pc_i2        (pc_i2),
    .pc_inv       (pc_inv),
    .pc_out       (pc_out),
    .prefetch_out (prefetch_out),
    .ir_out       (ir_out),
    .k16_out      (k16_out),
    .ir_valid     (ir_valid)
  );

  always #5 clk = ~clk;

  // Word at byte address a holds a/2.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {1'b0, a[15:1]};
  endfunction

  // Two-bank cache with one cycle of latency.
  always @(posedge clk) begin
    fetch_opc    <= mem_word({pc_out[15:2], 2'b00});
    fetch_arg    <= mem_word({pc_out[15:2], 2'b10});
    prefetch_opc <= mem_word(prefetch_out);
  end

  always @(posedge clk) last_hold <= hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ir(input logic [15:0] ir, input logic [15:0] k16);
    exp_q.push_back({ir, k16});
  endtask

  // Apply one cycle of controls and return 1 time unit after the edge.
  task automatic step(input logic w, input logic i2, input logic inc,
                      input logic inv, input logic hld, input logic [15:0] alu);
    pc_w   = w;
    pc_i2  = i2;
    pc_inc = inc;
    pc_inv = inv;
    hold   = hld;
    pc_alu = alu;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid capture after a non-hold edge must match the
  // next queued expectation.
  always @(negedge clk) begin
    if (a_rst && !last_hold && ir_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid_capture", {ir_out, k16_out}, 32'hxxxx_xxxx);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("capture_ir",  {16'h0, ir_out},  {16'h0, e[31:16]});
        check("capture_k16", {16'h0, k16_out}, {16'h0, e[15:0]});
      end
    end
  end

  initial begin
    // Reset state.
    #2;
    check("rst_pc",       {16'h0, pc_out},       32'h0000);
    check("rst_prefetch", {16'h0, prefetch_out}, 32'h0004);
    check("rst_ir",       {16'h0, ir_out},       32'h0000);
    check("rst_k16",      {16'h0, k16_out},      32'h0000);
    check("rst_valid",    {31'h0, ir_valid},     32'h0);
    @(posedge clk);
    #1;
    a_rst = 1'b1;

    // Idle after reset: first valid capture two edges later.
    step(0, 0, 0, 0, 0, 16'h0000);
    check("idle1_valid", {31'h0, ir_valid}, 32'h0);
    check("idle1_pc",    {16'h0, pc_out},   32'h0000);
    expect_ir(16'h0000, 16'h0001);
    step(0, 0, 0, 0, 0, 16'h0000);

    // Redirect to 0x0010 (bit 0 of pc_alu ignored).
    step(1, 0, 0, 0, 0, 16'h0011);
    check("br_pc",     {16'h0, pc_out},   32'h0010);
    check("br_valid1", {31'h0, ir_valid}, 32'h0);
    step(0, 0, 0, 0, 0, 16'h0000);
    check("br_valid2", {31'h0, ir_valid}, 32'h0);
    expect_ir(16'h0008, 16'h0009);
    step(0, 0, 0, 0, 0, 16'h0000);
    check("br_pc_hold", {16'h0, pc_out}, 32'h0010);

    // Sequential pc_inc from 0.
    step(1, 0, 0, 0, 0, 16'h0000);
    check("seq_start_pc", {16'h0, pc_out}, 32'h0000);
    step(0, 0, 1, 0, 0, 16'h0000);
    check("seq_pc2",    {16'h0, pc_out},   32'h0002);
    check("seq_valid0", {31'h0, ir_valid}, 32'h0);
    expect_ir(16'h0000, 16'h0001);
    step(0, 0, 1, 0, 0, 16'h0000);
    check("seq_pc4", {16'h0, pc_out}, 32'h0004);
`ifdef FETCH_UNALIGNED_EN
    expect_ir(16'h0001, 16'h0002);
`else
    expect_ir(16'h0000, 16'h0001);
`endif
    step(0, 0, 1, 0, 0, 16'h0000);
    check("seq_pc6", {16'h0, pc_out}, 32'h0006);
    expect_ir(16'h0002, 16'h0003);
    step(0, 0, 1, 0, 0, 16'h0000);
    check("seq_pc8", {16'h0, pc_out}, 32'h0008);

    // pc_i2 and pc_inc together from 4: pc_i2 wins.
    step(1, 0, 0, 0, 0, 16'h0004);
    check("i2_start_pc", {16'h0, pc_out},   32'h0004);
    check("i2_valid0",   {31'h0, ir_valid}, 32'h0);
    step(0, 1, 1, 0, 0, 16'h0000);
    check("i2_pc8",    {16'h0, pc_out},   32'h0008);
    check("i2_valid1", {31'h0, ir_valid}, 32'h0);
    expect_ir(16'h0002, 16'h0003);
    step(0, 1, 1, 0, 0, 16'h0000);
    check("i2_pcC", {16'h0, pc_out}, 32'h000C);
    expect_ir(16'h0004, 16'h0005);
    step(0, 1, 1, 0, 0, 16'h0000);
    check("i2_pc10", {16'h0, pc_out}, 32'h0010);

    // hold overrides pc_w and pc_inc; all visible state frozen.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 1, 16'h0040);
      check("hold_pc",    {16'h0, pc_out},   32'h0010);
      check("hold_ir",    {16'h0, ir_out},   32'h0004);
      check("hold_k16",   {16'h0, k16_out},  32'h0005);
      check("hold_valid", {31'h0, ir_valid}, 32'h1);
    end

    // Wrap at the top of the address space.
    step(1, 0, 0, 0, 0, 16'hFFFC);
    check("wrap_pc",       {16'h0, pc_out},       32'hFFFC);
    check("wrap_prefetch", {16'h0, prefetch_out}, 32'h0000);
    check("wrap_valid",    {31'h0, ir_valid},     32'h0);
    step(0, 1, 0, 0, 0, 16'h0000);
    check("wrap_pc0",       {16'h0, pc_out},       32'h0000);
    check("wrap_prefetch4", {16'h0, prefetch_out}, 32'h0004);
    expect_ir(16'h7FFE, 16'h7FFF);
    step(0, 0, 1, 0, 0, 16'h0000);
    check("inv_pc2", {16'h0, pc_out}, 32'h0002);

    // pc_inv pulse drops ir_valid while PC keeps stepping.
    step(0, 0, 1, 1, 0, 16'h0000);
    check("inv_pc4",    {16'h0, pc_out},   32'h0004);
    check("inv_valid1", {31'h0, ir_valid}, 32'h0);
    step(0, 0, 1, 0, 0, 16'h0000);
    check("inv_pc6",    {16'h0, pc_out},   32'h0006);
    check("inv_valid2", {31'h0, ir_valid}, 32'h0);
    expect_ir(16'h0002, 16'h0003);
    step(0, 0, 1, 0, 0, 16'h0000);
    check("inv_pc8", {16'h0, pc_out}, 32'h0008);
`ifdef FETCH_UNALIGNED_EN
    expect_ir(16'h0003, 16'h0004);
`else
    expect_ir(16'h0002, 16'h0003);
`endif
    step(0, 0, 0, 0, 0, 16'h0000);
    expect_ir(16'h0004, 16'h0005);
    step(0, 0, 0, 0, 0, 16'h0000);

    // Let the monitor see the last capture, then confirm nothing is left.
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-run, checked before any clock edge.
    a_rst = 1'b0;
    #1;
    check("arst_pc",       {16'h0, pc_out},       32'h0000);
    check("arst_prefetch", {16'h0, prefetch_out}, 32'h0004);
    check("arst_ir",       {16'h0, ir_out},       32'h0000);
    check("arst_k16",      {16'h0, k16_out},      32'h0000);
    check("arst_valid",    {31'h0, ir_valid},     32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
